// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the pipelined MIPS front end: opcode/funct
// encodings, ALU operation codes, the control bundle and the decode-stage FSM states.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ERET = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam int ALU_W = 4;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd10;

    typedef struct packed {
        logic             jump;
        logic             jal;
        logic             jr;
        logic             beq;
        logic             bne;
        logic             lui;
        logic             rtype;
        logic             reg_we;
        logic             mem_w;
        logic             load;
        logic             rfe;
        logic             illegal;
        logic             trap;
        logic [ALU_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
    } inst_fields_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } stage_state_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Stateless instruction-to-control-bundle decoder, plus field extraction and
// the register read set used by hazard detection.
module inst_decode_comb
    import ctrl_pkg::*;
(
    input  logic [31:0]  inst,
    output ctrl_t        ctrl,
    output inst_fields_t fields,
    output logic         reads_rs,
    output logic         reads_rt
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    ctrl_t      ctrl_s;
    logic       rd_rs_s;
    logic       rd_rt_s;

    assign op_s    = inst[31:26];
    assign funct_s = inst[5:0];

    assign fields = '{rs: inst[25:21], rt: inst[20:16], rd: inst[15:11],
                      shamt: inst[10:6], imm16: inst[15:0]};

    // Opcode/funct decode; unknown encodings collapse to a clean illegal bundle.
    always_comb begin
        ctrl_s  = CTRL_NONE;
        rd_rs_s = 1'b1;
        rd_rt_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                rd_rt_s       = 1'b1;
                ctrl_s.rtype  = 1'b1;
                ctrl_s.reg_we = 1'b1;
                case (funct_s)
                    F_ADD, F_ADDU: ctrl_s.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: ctrl_s.alu_op = ALU_SUB;
                    F_AND:         ctrl_s.alu_op = ALU_AND;
                    F_OR:          ctrl_s.alu_op = ALU_OR;
                    F_XOR:         ctrl_s.alu_op = ALU_XOR;
                    F_NOR:         ctrl_s.alu_op = ALU_NOR;
                    F_SLT:         ctrl_s.alu_op = ALU_SLT;
                    F_SLTU:        ctrl_s.alu_op = ALU_SLTU;
                    F_SLL:         ctrl_s.alu_op = ALU_SLL;
                    F_SRL:         ctrl_s.alu_op = ALU_SRL;
                    F_SRA:         ctrl_s.alu_op = ALU_SRA;
                    F_JR: begin
                        ctrl_s.jr     = 1'b1;
                        ctrl_s.reg_we = 1'b0;
                    end
                    F_JALR: begin
                        ctrl_s.jr    = 1'b1;
                        ctrl_s.jal   = 1'b1;
                        ctrl_s.rtype = 1'b0;
                    end
                    default: begin
                        ctrl_s         = CTRL_NONE;
                        ctrl_s.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl_s.alu_op = ALU_ADD;
                ctrl_s.reg_we = 1'b1;
                ctrl_s.load   = 1'b1;
            end
            OP_SW: begin
                rd_rt_s       = 1'b1;
                ctrl_s.alu_op = ALU_ADD;
                ctrl_s.mem_w  = 1'b1;
            end
            OP_BEQ: begin
                rd_rt_s       = 1'b1;
                ctrl_s.alu_op = ALU_SUB;
                ctrl_s.beq    = 1'b1;
            end
            OP_BNE: begin
                rd_rt_s       = 1'b1;
                ctrl_s.alu_op = ALU_SUB;
                ctrl_s.bne    = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_s.alu_op = ALU_ADD;
                ctrl_s.reg_we = 1'b1;
            end
            OP_SLTI: begin
                ctrl_s.alu_op = ALU_SLT;
                ctrl_s.reg_we = 1'b1;
            end
            OP_SLTIU: begin
                ctrl_s.alu_op = ALU_SLTU;
                ctrl_s.reg_we = 1'b1;
            end
            OP_ANDI: begin
                ctrl_s.alu_op = ALU_AND;
                ctrl_s.reg_we = 1'b1;
            end
            OP_ORI: begin
                ctrl_s.alu_op = ALU_OR;
                ctrl_s.reg_we = 1'b1;
            end
            OP_XORI: begin
                ctrl_s.alu_op = ALU_XOR;
                ctrl_s.reg_we = 1'b1;
            end
            OP_LUI: begin
                rd_rs_s       = 1'b0;
                ctrl_s.lui    = 1'b1;
                ctrl_s.reg_we = 1'b1;
            end
            OP_J: begin
                rd_rs_s     = 1'b0;
                ctrl_s.jump = 1'b1;
            end
            OP_JAL: begin
                rd_rs_s       = 1'b0;
                ctrl_s.jal    = 1'b1;
                ctrl_s.reg_we = 1'b1;
            end
            OP_COP0: begin
                if (funct_s == F_ERET) begin
                    ctrl_s.rfe = 1'b1;
                end else begin
                    ctrl_s.illegal = 1'b1;
                end
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    assign ctrl     = ctrl_s;
    assign reads_rs = rd_rs_s;
    assign reads_rt = rd_rt_s;

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered, handshaked decode stage: pipeline register, load-use bubble FSM,
// and interrupt-to-trap conversion gated by the pend/ie bits.
module decode_stage_pipe
    import ctrl_pkg::*;
#(
    parameter int AOPW = 4,
    parameter int PCW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            int_req,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PCW-1:0]  in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [15:0]     out_imm16,
    output logic            out_jump,
    output logic            out_jal,
    output logic            out_jr,
    output logic            out_beq,
    output logic            out_bne,
    output logic            out_lui,
    output logic            out_rtype,
    output logic            out_reg_we,
    output logic            out_mem_w,
    output logic            out_load,
    output logic            out_rfe,
    output logic            out_illegal,
    output logic            out_trap,
    output logic [AOPW-1:0] out_alu_op
);

    ctrl_t        dec_s;
    ctrl_t        issue_s;
    inst_fields_t fld_s;
    logic         rd_rs_s;
    logic         rd_rt_s;

    stage_state_t state_r;
    stage_state_t state_nxt_s;
    logic         valid_r;
    ctrl_t        ctl_r;
    inst_fields_t fld_r;
    logic [PCW-1:0] pc_r;
    logic         pend_r;
    logic         ie_r;

    logic hazard_s;
    logic accept_s;
    logic xfer_s;

    inst_decode_comb u_dec (
        .inst     (in_inst),
        .ctrl     (dec_s),
        .fields   (fld_s),
        .reads_rs (rd_rs_s),
        .reads_rt (rd_rt_s)
    );

    // A held load whose destination the incoming instruction reads must retire first.
    assign hazard_s = valid_r && ctl_r.load && (fld_r.rt != 5'd0) &&
                      ((rd_rs_s && (fld_s.rs == fld_r.rt)) ||
                       (rd_rt_s && (fld_s.rt == fld_r.rt)));

    assign in_ready = !flush && (state_r == ST_RUN) && !hazard_s && (!valid_r || out_ready);
    assign accept_s = in_valid && in_ready;
    assign xfer_s   = valid_r && out_ready;

    // A pending interrupt replaces the accepted instruction's bundle with a bare trap.
    always_comb begin
        issue_s = dec_s;
        if (pend_r) begin
            issue_s      = CTRL_NONE;
            issue_s.trap = 1'b1;
        end else begin
            issue_s = dec_s;
        end
    end

    // Next-state logic: the bubble is entered when the blocking load leaves the stage.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!flush && hazard_s && xfer_s && in_valid) begin
                    state_nxt_s = ST_BUBBLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BUBBLE: state_nxt_s = ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pipeline register: loads only on acceptance, flush drops the held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ctl_r   <= CTRL_NONE;
            fld_r   <= '0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            ctl_r   <= issue_s;
            fld_r   <= fld_s;
            pc_r    <= in_pc;
        end else if (xfer_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Interrupt latch and enable; the trapping acceptance takes precedence over new requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
            ie_r   <= 1'b1;
        end else if (accept_s && pend_r) begin
            pend_r <= 1'b0;
            ie_r   <= 1'b0;
        end else begin
            if (int_req && ie_r) begin
                pend_r <= 1'b1;
            end
            if (xfer_s && ctl_r.rfe) begin
                ie_r <= 1'b1;
            end
        end
    end

    assign out_valid   = valid_r;
    assign out_pc      = pc_r;
    assign out_rs      = fld_r.rs;
    assign out_rt      = fld_r.rt;
    assign out_rd      = fld_r.rd;
    assign out_shamt   = fld_r.shamt;
    assign out_imm16   = fld_r.imm16;
    assign out_jump    = ctl_r.jump;
    assign out_jal     = ctl_r.jal;
    assign out_jr      = ctl_r.jr;
    assign out_beq     = ctl_r.beq;
    assign out_bne     = ctl_r.bne;
    assign out_lui     = ctl_r.lui;
    assign out_rtype   = ctl_r.rtype;
    assign out_reg_we  = ctl_r.reg_we;
    assign out_mem_w   = ctl_r.mem_w;
    assign out_load    = ctl_r.load;
    assign out_rfe     = ctl_r.rfe;
    assign out_illegal = ctl_r.illegal;
    assign out_trap    = ctl_r.trap;
    assign out_alu_op  = AOPW'(ctl_r.alu_op);

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Registered, handshaked instruction-decode stage for the pipelined MIPS core. It replaces the single-cycle combinational control decoder and sits between IF and EX. It decodes the extended integer subset into a control bundle with a wider ALU-op code and an explicit illegal-instruction flag. It also inserts load-use bubbles and converts a latched interrupt request into a trap marker.

## Interface
- `AOPW`, 4: ALU-op width, ≥4. Codes are zero-extended to `AOPW` bits.
- `PCW`, 32: PC width carried alongside the instruction.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: discard the held entry and any pending bubble.
- `int_req` in 1: interrupt request level.
- `in_valid` in 1, `in_ready` out 1, `in_inst` in 32, `in_pc` in PCW: upstream handshake.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_pc` out PCW, `out_rs`/`out_rt`/`out_rd` out 5, `out_shamt` out 5, `out_imm16` out 16: registered instruction fields.
- `out_jump`, `out_jal`, `out_jr`, `out_beq`, `out_bne`, `out_lui`, `out_rtype`, `out_reg_we`, `out_mem_w`, `out_load`, `out_rfe`, `out_illegal`, `out_trap` out 1 each: control bits.
- `out_alu_op` out AOPW: ALU operation.

## Operation
- **ALU codes:** and 0, or 1, add 2, xor 3, nor 4, srl 5, sub 6, slt 7, sll 8, sra 9, sltu 10.
- **R-type (op 00):** `rtype=1`, `reg_we=1`.
  - funct 20/21 → add; 22/23 → sub; 24 → and; 25 → or; 26 → xor; 27 → nor; 2a → slt; 2b → sltu; 00 → sll; 02 → srl; 03 → sra.
  - funct 08 (jr): `jr=1`, `reg_we=0`.
  - funct 09 (jalr): `jr=1`, `jal=1`, `rtype=0`, `reg_we=1`.
- **I/J-type:**
  - lw 23: add, `reg_we`, `load`.
  - sw 2b: add, `mem_w`.
  - beq 04 / bne 05: sub, plus `beq` / `bne`.
  - addi 08 / addiu 09: add, `reg_we`.
  - slti 0a: slt, `reg_we`. sltiu 0b: sltu, `reg_we`.
  - andi 0c: and, `reg_we`. ori 0d: or, `reg_we`. xori 0e: xor, `reg_we`.
  - lui 0f: `lui`, `reg_we`.
  - j 02: `jump`. jal 03: `jal`, `reg_we`.
  - eret (op 10, funct 18): `rfe`.
- **Illegal encodings:** any other encoding sets `illegal=1` with every enable 0 and `alu_op=0`. The decoder never produces X.
- **Load-use hazard:** the held entry is valid with `out_load=1` and `out_rt≠0`, and the incoming instruction reads that register. rs is read by everything except j/jal/lui. rt is read by R-type, sw, beq and bne.
  - Response: `in_ready=0` until the load transfers out, then one forced bubble cycle (state BUBBLE, `out_valid=0`, `in_ready=0`), then back to RUN.
- **Interrupt:**
  - `int_req` sets `pend` when `ie=1`.
  - The next accepted instruction is emitted with `trap=1`, all enables 0, `alu_op=0`, and `out_pc` set to that instruction's PC.
  - On that acceptance `pend` clears and `ie` clears.
  - An emitted (transferred) `rfe` entry sets `ie=1`.
- **Flush:**
  - `in_ready=0` during the flush cycle.
  - `out_valid` is 0 next cycle and the state returns to RUN.
  - `pend` and `ie` are unchanged.
  - A handshake completing in the flush cycle still counts as transferred.

## Timing
- Latency is 1 cycle from input acceptance to `out_valid`. Throughput is 1 instruction per cycle with no hazard.
- `in_ready = !flush && state==RUN && !hazard && (!out_valid || out_ready)`. This is combinational and has no dependency on `in_valid`.
- **Reset values:** `out_valid=0`, every control/field output 0, `state=RUN`, `pend=0`, `ie=1`. `in_ready` becomes 1 after reset.
- Output fields hold while `out_valid && !out_ready`. They load only on input acceptance.
- `int_req` and acceptance in the same cycle: the interrupt is latched and applies to the next acceptance, not the current one.
- Reset asserted mid-stall or mid-bubble returns immediately to the reset values.

## Structure
- Package `ctrl_pkg` holds:
  - opcode and funct localparams;
  - the ALU-op code constants;
  - the control-bundle struct (all single-bit enables plus `alu_op`).
- Sub-module `inst_decode_comb` is a purely combinational instruction-to-bundle decoder. It holds no state and is reusable by a future multi-issue front end.
- The top level holds the pipeline register, the hazard compare, the RUN/BUBBLE FSM and the `pend`/`ie` bits.

## Test plan
- **Basic decode:** add, xori, sra, sltiu, jalr, eret back-to-back with `out_ready=1`.
  - Outputs appear one cycle after each accept.
  - xori gives `alu_op=3`; sltiu gives `alu_op=10`; jalr gives `jr=1`, `jal=1`, `reg_we=1`, `rtype=0`.
- **Illegal encoding:** op 3f.
  - `illegal=1`, all enables 0, `alu_op=0`, and no X on any output.
- **Load-use:** lw $8, then add $9,$8,$1.
  - `in_ready=0` until lw transfers, then one `out_valid=0` cycle, then add is emitted.
  - lw $0 followed by an instruction reading $0 inserts no bubble.
- **Backpressure:** `out_ready=0` for 3 cycles with the entry held.
  - Fields stable, `in_ready=0`, no instruction lost or duplicated.
- **Interrupt:** pulse `int_req`, then accept an instruction at PC 0x40.
  - Output has `trap=1` and `out_pc=0x40`.
  - A second `int_req` is ignored until an eret is emitted.
- **Flush:** assert `flush` while held in BUBBLE with a pending interrupt.
  - Next cycle `out_valid=0` and state is RUN.
  - `pend` is still set, so the next accepted instruction traps.
